// File: rtl/vnu_pkg.sv
// Shared defaults and helpers for the two's-complement to sign-magnitude pipe.
// Optional per-frame saturation counter is enabled by defining T2S_SAT_CNT_EN.
package vnu_pkg;

  localparam int DATA_WIDTH_DEF = 5;
  localparam int CNT_WIDTH_DEF  = 8;
  localparam int SIGN_BIT       = DATA_WIDTH_DEF - 1;

  // Occupancy of the 2-entry elastic buffer.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_occ_e;

  function automatic int sign_bit_of(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/t2s_skid.sv
// Two-entry elastic buffer with a registered ready; the head entry drives the
// output directly, so accepted data appears on pop_data right after the accepting edge.
module t2s_skid
  import vnu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  skid_occ_e        occ;
  skid_occ_e        occ_next;
  logic             ready_q;
  logic             push;
  logic             pop;

  assign push       = push_valid & ready_q;
  assign pop        = (occ != SKID_EMPTY) & pop_ready;
  assign push_ready = ready_q;
  assign pop_valid  = (occ != SKID_EMPTY);
  assign pop_data   = mem[rd_ptr];

  // NOTE: occ_next gets its default before the case so no latch is inferred.
  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = (occ == SKID_EMPTY) ? SKID_ONE : SKID_FULL;
      2'b01:   occ_next = (occ == SKID_FULL) ? SKID_ONE : SKID_EMPTY;
      default: occ_next = occ;
    endcase
  end

  // NOTE: the storage is reset on purpose: it drives out_data, which must read 0 in reset.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      occ     <= SKID_EMPTY;
      ready_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ     <= occ_next;
      // Ready is a pure function of the next occupancy, never of pop_ready directly.
      ready_q <= (occ_next != SKID_FULL);
    end
  end

endmodule

// File: rtl/t_to_s_pipe.sv
// Two's-complement to sign-magnitude converter behind a 2-entry skid buffer.
// Define T2S_SAT_CNT_EN to add the per-frame saturation counter and its strobe.
module t_to_s_pipe
  import vnu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  sat_cnt,
  output logic                  sat_cnt_valid
);

  localparam int              SB      = sign_bit_of(DATA_WIDTH);
  localparam int              PW      = DATA_WIDTH + 2;
  localparam logic [SB-1:0]   MAG_ONE = SB'(1);

  logic [DATA_WIDTH-1:0] conv_data;
  logic                  conv_sat;
  logic [PW-1:0]         push_data;
  logic [PW-1:0]         pop_data;
  logic                  pop_sat;

  // The most-negative value has no positive counterpart, so it clamps to max magnitude.
  always_comb begin
    conv_data = in_data;
    conv_sat  = 1'b0;
    if (in_data[SB]) begin
      conv_data[SB] = 1'b1;
      if (in_data[SB-1:0] == '0) begin
        conv_data[SB-1:0] = '1;
        conv_sat          = 1'b1;
      end else begin
        conv_data[SB-1:0] = (~in_data[SB-1:0]) + MAG_ONE;
      end
    end
  end

  assign push_data = {conv_sat, in_last, conv_data};

  t2s_skid #(
    .WIDTH (PW)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (push_data),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (pop_data)
  );

  assign {pop_sat, out_last, out_data} = pop_data;

`ifdef T2S_SAT_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 fire;
  logic [CNT_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] next_total;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 strobe_q;

  // Saturated samples are tallied as they leave, so each is attributed to the frame
  // its out_last closes even when the next frame is already queued in the buffer.
  assign fire       = out_valid & out_ready;
  assign next_total = (pop_sat && (acc != '1)) ? acc + CNT_ONE : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= fire & out_last;
      if (fire) begin
        if (out_last) begin
          cnt_q <= next_total;
          acc   <= '0;
        end else begin
          acc <= next_total;
        end
      end
    end
  end

  assign sat_cnt       = cnt_q;
  assign sat_cnt_valid = strobe_q;
`else
  logic unused_sat;

  assign unused_sat    = pop_sat;
  assign sat_cnt       = '0;
  assign sat_cnt_valid = 1'b0;
`endif

endmodule

// File: tb/tb_t_to_s_pipe.sv
// Self-checking bench for t_to_s_pipe: directed scenarios plus randomized traffic
// against a queue-based reference model; adapts to builds with/without T2S_SAT_CNT_EN.
module tb_t_to_s_pipe;

  localparam int DW = 5;
  localparam int CW = 8;
`ifdef T2S_SAT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam logic [DW-1:0] NEG_MAX = {1'b1, {(DW-1){1'b0}}};
  localparam int            CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic [CW-1:0] sat_cnt;
  logic          sat_cnt_valid;

  t_to_s_pipe #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .sat_cnt       (sat_cnt),
    .sat_cnt_valid (sat_cnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference conversion from the arithmetic definition.
  function automatic logic [DW-1:0] ref_sm(input logic [DW-1:0] raw);
    int v;
    int m;
    int max_mag;
    max_mag = (1 << (DW - 1)) - 1;
    v = $signed(raw);
    if (v >= 0) return raw;
    m = -v;
    if (m > max_mag) m = max_mag;
    return DW'(m + (1 << (DW - 1)));
  endfunction

  logic [DW:0]   exp_q[$];
  int            strobe_q[$];
  int            frame_sat = 0;
  logic [DW-1:0] cap_q[$];
  int            sv_q[$];
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  // Model and monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    logic [DW:0] e;
    int v;
    if (in_valid && in_ready) begin
      exp_q.push_back({in_last, ref_sm(in_data)});
      v = $signed(in_data);
      if (v == -(1 << (DW - 1))) frame_sat++;
      if (in_last) begin
        if (CNT_EN) strobe_q.push_back(frame_sat > CNT_MAX ? CNT_MAX : frame_sat);
        frame_sat = 0;
      end
    end
    if (prev_stall && out_valid) begin
      check("hold_data", out_data, prev_data);
      check("hold_last", out_last, prev_last);
    end
    if (out_valid && out_ready) begin
      check("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data", out_data, e[DW-1:0]);
        check("out_last", out_last, e[DW]);
      end
      cap_q.push_back(out_data);
    end
    if (sat_cnt_valid) begin
      check("strobe_expected", strobe_q.size() != 0, 1);
      if (strobe_q.size() != 0) check("sat_cnt", sat_cnt, strobe_q.pop_front());
      sv_q.push_back(int'(sat_cnt));
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
  end

  // Presents one sample and returns at posedge+1 after it is accepted.
  task automatic drive(input logic [DW-1:0] d, input logic l, input bit rand_bp, input bit rand_gap);
    bit got;
    got = 1'b0;
    if (rand_gap) begin
      repeat ($urandom_range(0, 2)) begin
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int n = 0; n < 200; n++) begin
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      if (got) break;
    end
    check("accepted", got, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 0);
    check("strobes_done", strobe_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] tbl_in [5];
    logic [DW-1:0] tbl_exp [5];
    logic [DW-1:0] bp [8];
    logic [DW-1:0] frame_a [5];
    logic [DW-1:0] frame_b [4];
    int            exp_sv [2];
    int            idx;

    tbl_in  = '{5'b00000, 5'b00111, 5'b11111, 5'b10001, 5'b10000};
    tbl_exp = '{5'b00000, 5'b00111, 5'b10001, 5'b11111, 5'b11111};
    frame_a = '{5'd1, NEG_MAX, NEG_MAX, 5'd3, NEG_MAX};
    frame_b = '{5'd2, 5'b11101, 5'd5, 5'd0};
    exp_sv  = '{3, 0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_sat_valid", sat_cnt_valid, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    check("in_ready_after_edge", in_ready, 1);

    // Conversion table and single-cycle latency
    out_ready = 1'b1;
    cap_q.delete();
    sv_q.delete();
    for (int i = 0; i < 5; i++) begin
      drive(tbl_in[i], i == 4, 1'b0, 1'b0);
      if (i == 0) begin
        check("latency_valid", out_valid, 1);
        check("latency_data", out_data, tbl_exp[0]);
      end
    end
    drain();
    check("table_count", cap_q.size(), 5);
    for (int i = 0; i < cap_q.size(); i++) check($sformatf("table_%0d", i), cap_q[i], tbl_exp[i]);
    check("table_strobes", sv_q.size(), CNT_EN ? 1 : 0);

    // Backpressure: only two accepts with out_ready low
    for (int i = 0; i < 8; i++) bp[i] = DW'($urandom);
    out_ready = 1'b0;
    cap_q.delete();
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_data = bp[idx]; in_last = (idx == 7);
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    check("bp_accepts", idx, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_no_output", cap_q.size(), 0);
    out_ready = 1'b1;
    for (int c = 0; c < 100 && idx < 8; c++) begin
      in_valid = 1'b1; in_data = bp[idx]; in_last = (idx == 7);
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_all_sent", idx, 8);
    drain();
    check("bp_count", cap_q.size(), 8);
    for (int i = 0; i < cap_q.size(); i++) check($sformatf("bp_order_%0d", i), cap_q[i], ref_sm(bp[i]));

    // Saturation frame followed by a clean frame
    sv_q.delete();
    for (int i = 0; i < 5; i++) drive(frame_a[i], i == 4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(frame_b[i], i == 3, 1'b0, 1'b0);
    drain();
    check("sat_strobe_count", sv_q.size(), CNT_EN ? 2 : 0);
    for (int i = 0; i < sv_q.size() && i < 2; i++) check($sformatf("sat_frame_%0d", i), sv_q[i], exp_sv[i]);
    check("sat_cnt_hold_zero", sat_cnt, 0);

    // Counter sticks at its maximum
    sv_q.delete();
    for (int i = 0; i < 300; i++) drive(NEG_MAX, i == 299, 1'b0, 1'b0);
    drain();
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("sticky_strobes", sv_q.size(), CNT_EN ? 1 : 0);
    check("sticky_hold", sat_cnt, CNT_EN ? CNT_MAX : 0);

    // Randomized traffic with backpressure and gaps
    for (int i = 0; i < 200; i++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? NEG_MAX : DW'($urandom);
      drive(d, ($urandom_range(0, 5) == 0) || (i == 199), 1'b1, 1'b1);
    end
    drain();

    // Reset mid-frame with the buffer full
    out_ready = 1'b0;
    drive(NEG_MAX, 1'b0, 1'b0, 1'b0);
    drive(5'd3, 1'b0, 1'b0, 1'b0);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_sat_cnt", sat_cnt, 0);
    check("mid_rst_sat_valid", sat_cnt_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
    strobe_q.delete();
    frame_sat = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    sv_q.delete();
    drive(NEG_MAX, 1'b0, 1'b0, 1'b0);
    drive(5'd4, 1'b1, 1'b0, 1'b0);
    drain();
    check("post_rst_strobes", sv_q.size(), CNT_EN ? 1 : 0);
    for (int i = 0; i < sv_q.size(); i++) check("post_rst_count", sv_q[i], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
